cpm_fifo_unpacker: RTL and testbench

//  Read side of a CPM FIFO (show-ahead, combinational read data). Pops IN_WIDTH words and

---
 rtl/cpm_fifo_unpacker.sv | 95 +++++++++
 tb/tb_cpm_fifo_unpacker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpm_fifo_unpacker.sv
// cpm_fifo_unpacker: pops wide CPM FIFO words and streams each as RATIO narrow beats.
// Define CPM_UNPACK_MSB_FIRST_EN to emit the most significant beat of each word first.
module cpm_fifo_unpacker #(
    parameter int IN_WIDTH    = 64,
    parameter int OUT_WIDTH   = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   Reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_words,
    input  logic                   fifo_empty,
    input  logic [IN_WIDTH-1:0]    fifo_data,
    output logic                   fifo_pop,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int BW = $clog2(RATIO);
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t                 state;
    logic [IN_WIDTH-1:0]    sreg;
    logic [IN_WIDTH-1:0]    sreg_next;
    logic [BW-1:0]          beat_cnt;
    logic [COUNT_WIDTH-1:0] word_cnt;
    logic [COUNT_WIDTH-1:0] num_q;
    logic                   last_beat;
    logic                   last_word;

    assign last_beat = beat_cnt == LAST_BEAT;
    assign last_word = word_cnt == num_q - COUNT_WIDTH'(1);

`ifdef CPM_UNPACK_MSB_FIRST_EN
    assign out_data  = sreg[IN_WIDTH-1 -: OUT_WIDTH];
    assign sreg_next = sreg << OUT_WIDTH;
`else
    assign out_data  = sreg[OUT_WIDTH-1:0];
    assign sreg_next = sreg >> OUT_WIDTH;
`endif

    // Pop is suppressed under Reset since the word would never be captured.
    assign fifo_pop  = state == FETCH && !fifo_empty && !Reset;
    assign out_valid = state == SEND;
    assign out_last  = out_valid && last_beat && last_word;
    assign busy      = state != IDLE;
    assign done      = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sreg     <= '0;
            beat_cnt <= '0;
            word_cnt <= '0;
            num_q    <= '0;
        end else if (Reset) begin
            state    <= IDLE;
            sreg     <= '0;
            beat_cnt <= '0;
            word_cnt <= '0;
            num_q    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    num_q <= num_words;
                    state <= num_words != '0 ? FETCH : DONE;
                end
                FETCH: if (!fifo_empty) begin
                    sreg     <= fifo_data;
                    beat_cnt <= '0;
                    state    <= SEND;
                end
                SEND: if (out_ready) begin
                    sreg     <= sreg_next;
                    beat_cnt <= beat_cnt + BW'(1);
                    if (last_beat) begin
                        word_cnt <= word_cnt + COUNT_WIDTH'(1);
                        state    <= last_word ? DONE : FETCH;
                    end
                end
                DONE: begin
                    word_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpm_fifo_unpacker.sv
// tb_cpm_fifo_unpacker: directed table-driven bench for cpm_fifo_unpacker with a show-ahead FIFO model.
module tb_cpm_fifo_unpacker;
    logic        clk = 0, rst_n = 0, Reset = 0, start = 0, out_ready = 1;
    logic        fifo_empty, fifo_pop, out_valid, out_last, busy, done;
    logic [15:0] num_words = 0, out_data;
    logic [63:0] fifo_data;
    logic [63:0] mem [16];
    int          wr_ptr = 0, rd_ptr = 0, cyc = 0, first_pop = -1, last_cyc = 0, done_cyc = 0, done_cnt = 0;
    int          checks = 0, errors = 0;
    logic [16:0] beats [$];
    logic        hold_chk = 0, held_l = 0;
    logic [15:0] held_d = 0;

    typedef struct {
        logic [63:0]       word;
        logic [3:0][15:0]  b;
    } vec_t;
    vec_t tbl [3];

    cpm_fifo_unpacker #(.IN_WIDTH(64), .OUT_WIDTH(16), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .Reset(Reset), .start(start), .num_words(num_words),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = rd_ptr == wr_ptr;
    assign fifo_data  = mem[rd_ptr % 16];

    always @(posedge clk) if (fifo_pop) rd_ptr <= rd_ptr + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (hold_chk) chk("hold_stall", {out_valid, out_last, out_data}, {1'b1, held_l, held_d});
        hold_chk = out_valid && !out_ready;
        held_d   = out_data;
        held_l   = out_last;
        if (out_valid && out_ready) begin
            beats.push_back({out_last, out_data});
            last_cyc = cyc;
        end
        if (fifo_pop && first_pop < 0) first_pop = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] w);
        mem[wr_ptr % 16] = w;
        wr_ptr++;
    endtask

    task automatic start_xfer(input logic [15:0] n);
        start     = 1;
        num_words = n;
        step();
        start = 0;
    endtask

    task automatic wait_done(input int budget, input bit toggle, input bit poke);
        int d0;
        d0 = done_cnt;
        for (int n = 0; n < budget && done_cnt == d0; n++) begin
            step();
            if (toggle) out_ready = ~out_ready;
            start = poke && n == 5;
        end
        start = 0;
        out_ready = 1;
        chk("done_seen", done_cnt != d0, 1);
    endtask

    task automatic check_beats(input int nw);
        logic [16:0] a;
        chk("beat_count", beats.size(), nw * 4);
        for (int i = 0; i < nw * 4; i++) begin
            a = i < beats.size() ? beats[i] : 17'h1ffff;
            chk($sformatf("beat%0d", i), a, {i == nw * 4 - 1, tbl[i / 4].b[i % 4]});
        end
    endtask

    initial begin
        int p0, d0;
`ifdef CPM_UNPACK_MSB_FIRST_EN
        tbl[0] = '{64'h4444_3333_2222_1111, {16'h1111, 16'h2222, 16'h3333, 16'h4444}};
        tbl[1] = '{64'h8888_7777_6666_5555, {16'h5555, 16'h6666, 16'h7777, 16'h8888}};
        tbl[2] = '{64'hCCCC_BBBB_AAAA_9999, {16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC}};
`else
        tbl[0] = '{64'h4444_3333_2222_1111, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
        tbl[1] = '{64'h8888_7777_6666_5555, {16'h8888, 16'h7777, 16'h6666, 16'h5555}};
        tbl[2] = '{64'hCCCC_BBBB_AAAA_9999, {16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h9999}};
`endif
        step();
        step();
        chk("reset_outputs", {out_valid, out_last, busy, done, fifo_pop, out_data}, 0);
        rst_n = 1;
        step();
        chk("idle_after_reset", {out_valid, busy, done}, 0);

        // single word, full-rate
        push(tbl[0].word);
        p0 = rd_ptr;
        beats.delete();
        start_xfer(1);
        wait_done(100, 0, 0);
        check_beats(1);
        chk("t1_pops", rd_ptr - p0, 1);
        chk("t1_done_latency", done_cyc - last_cyc, 1);

        // three preloaded words: 12 beats over 15 cycles
        for (int i = 0; i < 3; i++) push(tbl[i].word);
        p0 = rd_ptr;
        first_pop = -1;
        beats.delete();
        start_xfer(3);
        wait_done(100, 0, 0);
        check_beats(3);
        chk("t3_pops", rd_ptr - p0, 3);
        chk("t3_span", last_cyc - first_pop, 14);

        // ready toggling, with a start pulse while busy that must be ignored
        for (int i = 0; i < 3; i++) push(tbl[i].word);
        d0 = done_cnt;
        beats.delete();
        start_xfer(3);
        wait_done(200, 1, 1);
        repeat (10) step();
        check_beats(3);
        chk("t4_single_done", done_cnt - d0, 1);

        // FIFO empty while fetching
        beats.delete();
        start_xfer(1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5_starve%0d", i), {fifo_pop, out_valid, busy}, 3'b001);
            step();
        end
        push(tbl[0].word);
        #1;
        chk("t5_pop_same_cycle", fifo_pop, 1);
        step();
        chk("t5_first_beat", {out_valid, out_data}, {1'b1, tbl[0].b[0]});
        wait_done(100, 0, 0);
        check_beats(1);

        // zero-length transfer
        p0 = rd_ptr;
        start_xfer(0);
        chk("t6_done_pulse", {done, out_valid}, 2'b10);
        step();
        chk("t6_done_clear", {done, busy}, 0);
        chk("t6_no_pop", rd_ptr - p0, 0);

        // abort during word 2 of 4
        for (int i = 0; i < 3; i++) push(tbl[i].word);
        push(tbl[0].word);
        p0 = rd_ptr;
        beats.delete();
        start_xfer(4);
        for (int n = 0; n < 100 && beats.size() < 5; n++) step();
        chk("t6_mid_send", {out_valid, beats.size() >= 5}, 2'b11);
        Reset = 1;
        d0 = done_cnt;
        step();
        Reset = 0;
        chk("t6_abort_idle", {out_valid, out_last, busy, done, fifo_pop, out_data}, 0);
        repeat (5) step();
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_abort_pops", rd_ptr - p0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
